// File: rtl/myproject_mul_pipe_acc_pkg.sv
// Shared constants for the pipelined multiply / multiply-accumulate unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: legal NUM_STAGE range, ACC_MODE encodings, and a stage-range check helper.
package myproject_mul_pipe_acc_pkg;

   localparam int MUL_PIPE_MAX_STAGE = 4;
   localparam int MUL_PIPE_MIN_STAGE = 1;

   localparam int MUL_MODE_MUL = 0;
   localparam int MUL_MODE_ACC = 1;

   function automatic bit mul_pipe_stage_ok(int num_stage);
      return (num_stage >= MUL_PIPE_MIN_STAGE) && (num_stage <= MUL_PIPE_MAX_STAGE);
   endfunction

endpackage

// File: rtl/myproject_mul_pipe_acc_if.sv
// Operand/result bundle for the pipelined multiply / MAC unit.
// Latency: n/a (wires only).
// Backpressure: none; the ce input on the unit is the only stall mechanism.
// Ports: din_vld/din0/din1/din_last from the producer, dout_vld/dout back to it.
//   master = the side that supplies operands; slave = the multiplier.
interface myproject_mul_pipe_acc_if #(
   parameter int din0_WIDTH = 8,
   parameter int din1_WIDTH = 8,
   parameter int dout_WIDTH = 16
);
   logic                  din_vld;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic                  din_last;
   logic                  dout_vld;
   logic [dout_WIDTH-1:0] dout;

   modport master (
      output din_vld, din0, din1, din_last,
      input  dout_vld, dout
   );

   modport slave (
      input  din_vld, din0, din1, din_last,
      output dout_vld, dout
   );
endinterface

// File: rtl/myproject_mul_pipe_acc_sr.sv
// Clock-enabled delay line used to carry {valid, last, product} down the pipe.
// Latency: DEPTH ce-enabled cycles (DEPTH >= 1).
// Backpressure: ce=0 freezes every stage; rst (sync, active-high) clears all stages and wins over ce.
// Ports: clk, rst, ce, din[WIDTH], dout[WIDTH].
module myproject_mul_pipe_sr #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stg [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stg[i] <= '0;
         end
      end else if (ce) begin
         stg[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign dout = stg[DEPTH-1];

endmodule

// File: rtl/myproject_mul_pipe_acc.sv
// Pipelined mixed-sign multiplier with optional accumulate-until-last mode.
// Latency: NUM_STAGE ce-enabled cycles from operand sample to result (fully pipelined, 1 beat/cycle).
// Backpressure: none; ce=0 freezes the whole pipe, the accumulator and dout_vld.
// Ports: ap_clk, ap_rst (sync, active-high), ce, bus (slave: din_vld/din0/din1/din_last in,
//   dout_vld/dout out).
module myproject_mul_pipe_acc
   import myproject_mul_pipe_acc_pkg::*;
#(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 3,
   parameter int din0_WIDTH  = 8,
   parameter int din1_WIDTH  = 8,
   parameter int din0_SIGNED = 0,
   parameter int din1_SIGNED = 1,
   parameter int dout_WIDTH  = 16,
   parameter int ACC_MODE    = MUL_MODE_MUL
) (
   input logic                     ap_clk,
   input logic                     ap_rst,
   input logic                     ce,
   myproject_mul_pipe_acc_if.slave bus
);

   // Two extra bits let both operands be treated as signed, which makes one
   // signed multiply exact for every signedness combination.
   localparam int PW  = din0_WIDTH + din1_WIDTH + 2;
   localparam int SRW = dout_WIDTH + 2;

   if (!mul_pipe_stage_ok(NUM_STAGE)) begin : g_bad_stage
      $fatal(1, "myproject_mul_pipe_acc ID %0d: NUM_STAGE=%0d outside %0d..%0d",
             ID, NUM_STAGE, MUL_PIPE_MIN_STAGE, MUL_PIPE_MAX_STAGE);
   end

   logic signed [din0_WIDTH:0] op0;
   logic signed [din1_WIDTH:0] op1;
   logic signed [PW-1:0]       prod_full;
   logic [dout_WIDTH-1:0]      prod_rs;
   logic [SRW-1:0]             stage_in;
   logic [SRW-1:0]             stage_out;

   logic                  s_vld;
   logic                  s_last;
   logic [dout_WIDTH-1:0] s_prod;
   logic                  is_last;
   logic [dout_WIDTH-1:0] acc_sum;

   logic                  vld_q;
   logic [dout_WIDTH-1:0] dout_q;
   logic [dout_WIDTH-1:0] acc_q;

   assign op0 = {(din0_SIGNED != 0) && bus.din0[din0_WIDTH-1], bus.din0};
   assign op1 = {(din1_SIGNED != 0) && bus.din1[din1_WIDTH-1], bus.din1};

   assign prod_full = PW'(op0) * PW'(op1);

   // prod_full is the exact value, so a signed resize truncates when narrowing
   // and extends correctly when widening (an all-unsigned product is never
   // negative, so sign extension equals zero extension there).
   assign prod_rs = dout_WIDTH'(prod_full);

   assign stage_in = {bus.din_vld, bus.din_last, prod_rs};

   // NUM_STAGE-1 delay stages here, plus the output register below.
   if (NUM_STAGE > 1) begin : g_pipe
      myproject_mul_pipe_sr #(
         .WIDTH (SRW),
         .DEPTH (NUM_STAGE - 1)
      ) u_sr (
         .clk  (ap_clk),
         .rst  (ap_rst),
         .ce   (ce),
         .din  (stage_in),
         .dout (stage_out)
      );
   end else begin : g_no_pipe
      assign stage_out = stage_in;
   end

   assign {s_vld, s_last, s_prod} = stage_out;

   // In multiply mode every beat closes its own "group" and the accumulator
   // never contributes, so both modes share one output stage.
   assign is_last = (ACC_MODE == MUL_MODE_MUL) || s_last;
   assign acc_sum = (ACC_MODE == MUL_MODE_ACC) ? acc_q + s_prod : s_prod;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         vld_q  <= 1'b0;
         dout_q <= '0;
         acc_q  <= '0;
      end else if (ce) begin
         vld_q <= s_vld && is_last;
         if (s_vld) begin
            if (is_last) begin
               dout_q <= acc_sum;
               acc_q  <= '0;
            end else begin
               acc_q  <= acc_sum;
            end
         end
      end
   end

   assign bus.dout_vld = vld_q;
   assign bus.dout     = dout_q;

endmodule
